// File: rtl/csa_pkg.sv
// Shared sizing helpers for the pipelined carry-save multi-operand adder.
// Row counts and level counts are evaluated at elaboration time by the top.
package csa_pkg;

    // Output width for the default configuration of 8 operands of 8 bits.
    localparam int OUT_W = 8 + 3;

    function automatic int csa_rows(input int n, input int lvl);
        int r;
        r = n;
        for (int i = 0; i < lvl; i++) begin
            r = 2 * (r / 3) + r % 3;
        end
        return r;
    endfunction

    function automatic int csa_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        for (int i = 0; i < 32; i++) begin
            if (r > 2) begin
                r = 2 * (r / 3) + r % 3;
                l++;
            end
        end
        return l;
    endfunction

endpackage

// File: rtl/csa_3to2.sv
// One row of full adders: three addends in, a sum row and a carry row out.
// The carry row is already shifted into its binary weight.
import csa_pkg::*;

module csa_3to2 #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] s_o,
    output logic [W-1:0] co_o
);

    logic [W-2:0] maj_lo;

    assign s_o    = a_i ^ b_i ^ c_i;
    // The top bit's majority would shift out of range, so it is never formed.
    assign maj_lo = (a_i[W-2:0] & b_i[W-2:0]) | (a_i[W-2:0] & c_i[W-2:0]) | (b_i[W-2:0] & c_i[W-2:0]);
    assign co_o   = {maj_lo, 1'b0};

endmodule

// File: rtl/csa_tree_adder_pipe.sv
// Pipelined Wallace-style multi-operand adder: one register per 3:2 level,
// then a registered carry-propagate add; the whole pipe stalls together.
import csa_pkg::*;

module csa_tree_adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int N_OPS  = 8,
    parameter int SIGNED = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [N_OPS*WIDTH-1:0]           in_ops,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH+$clog2(N_OPS)-1:0]   out_sum
);

    localparam int OW    = WIDTH + $clog2(N_OPS);
    localparam int L     = csa_levels(N_OPS);
    localparam int EXT_W = OW - WIDTH;

    logic          adv;
    logic [L:0]    vld_q;
    logic [OW-1:0] sum_d;
    logic [OW-1:0] sum_q;
    logic [OW-1:0] ext [N_OPS];

    assign adv       = !vld_q[L] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[L];
    assign out_sum   = sum_q;

    for (genvar k = 0; k < N_OPS; k++) begin : g_ext
        logic [WIDTH-1:0] op;
        assign op = in_ops[k*WIDTH +: WIDTH];
        assign ext[k] = (SIGNED != 0) ? {{EXT_W{op[WIDTH-1]}}, op} : {{EXT_W{1'b0}}, op};
    end

    // Each level compresses triples and forwards leftovers, then registers its rows.
    for (genvar g = 0; g < L; g++) begin : g_lvl
        localparam int NI = csa_rows(N_OPS, g);
        localparam int NT = NI / 3;
        localparam int NR = NI % 3;
        localparam int NO = csa_rows(N_OPS, g + 1);

        logic [OW-1:0] src   [NI];
        logic [OW-1:0] row_d [NO];
        logic [OW-1:0] row_q [NO];

        for (genvar k = 0; k < NI; k++) begin : g_src
            if (g == 0) begin : g_first
                assign src[k] = ext[k];
            end else begin : g_next
                assign src[k] = g_lvl[g-1].row_q[k];
            end
        end

        for (genvar t = 0; t < NT; t++) begin : g_tri
            csa_3to2 #(.W(OW)) u_csa (
                .a_i  (src[3*t]),
                .b_i  (src[3*t+1]),
                .c_i  (src[3*t+2]),
                .s_o  (row_d[2*t]),
                .co_o (row_d[2*t+1])
            );
        end

        for (genvar r = 0; r < NR; r++) begin : g_pass
            assign row_d[2*NT+r] = src[3*NT+r];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < NO; i++) row_q[i] <= '0;
            end else if (adv) begin
                for (int i = 0; i < NO; i++) row_q[i] <= row_d[i];
            end
        end
    end

    // Final carry-propagate stage; the modular wrap at OW bits is exact.
    assign sum_d = g_lvl[L-1].row_q[0] + g_lvl[L-1].row_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            sum_q <= '0;
        end else if (adv) begin
            vld_q <= {vld_q[L-1:0], in_valid};
            sum_q <= sum_d;
        end
    end

endmodule
